// File: rtl/bids22_cmd_responder_if.sv
// bids22_cmd_responder_if: command handshake between the tester/BFM initiator and the responder.
interface bids22_cmd_responder_if #(
  parameter int CDATA_W = 32
);
  logic               C_start;
  logic [3:0]         C_op;
  logic [CDATA_W-1:0] C_data;
  logic               ready;
  logic [2:0]         err;
  logic               roundOver;
  modport master (output C_start, C_op, C_data, input ready, err, roundOver);
  modport slave (input C_start, C_op, C_data, output ready, err, roundOver);
endinterface

// File: rtl/bids22_cmd_responder.sv
// bids22_cmd_responder: executes BIDS22 commands (lock/key, balances, mask, charge, round timer).
// Optional BIDS22_KEY_LOCKOUT_EN: third consecutive bad key locks the responder out until reset.
module bids22_cmd_responder #(
  parameter int                 CDATA_W         = 32,
  parameter int                 COOLDOWN_CYCLES = 7,
  parameter logic [15:0]        DEFAULT_TIMER   = 16'h000F,
  parameter logic [CDATA_W-1:0] DEFAULT_CHARGE  = CDATA_W'(1)
) (
  input  logic                  clk,
  input  logic                  reset,
  bids22_cmd_responder_if.slave bus,
  output logic                  round_active,
  output logic [CDATA_W-1:0]    X_balance,
  output logic [CDATA_W-1:0]    Y_balance,
  output logic [CDATA_W-1:0]    Z_balance,
  output logic [2:0]            mask,
  output logic [CDATA_W-1:0]    bid_charge,
  output logic [15:0]           timer_remaining
);
  localparam int CW = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [3:0] OP_UNLOCK = 4'd1, OP_LOCK = 4'd2, OP_LOADX = 4'd3, OP_LOADY = 4'd4,
                         OP_LOADZ = 4'd5, OP_MASK = 4'd6, OP_TIMER = 4'd7, OP_CHARGE = 4'd8,
                         OP_RDACT = 4'd9, OP_RDOVR = 4'd10;
  typedef enum logic [2:0] {UNLOCKED, LOCKED, ROUND_ACTIVE, COOLDOWN, LOCKOUT} state_t;
  state_t             state_q;
  logic               ready_q, ro_q, active_q;
  logic [2:0]         err_q, err_d, mask_q;
  logic [CDATA_W-1:0] x_q, y_q, z_q, charge_q, key_q;
  logic [15:0]        tlen_q, trem_q;
  logic [CW-1:0]      cool_q;
`ifdef BIDS22_KEY_LOCKOUT_EN
  logic [1:0]         bad_q;
`endif
  logic [3:0]         op;
  logic [CDATA_W-1:0] data;
  logic               acc, ok, is_write, key_ok;
  assign op       = bus.C_op;
  assign data     = bus.C_data;
  assign acc      = bus.C_start && ready_q;
  assign ok       = acc && err_d == 3'b000;
  assign is_write = op >= OP_LOADX && op <= OP_CHARGE;
  assign key_ok   = data == key_q;
  always_comb begin
    err_d = 3'b000;
    if (op > OP_RDOVR) err_d = 3'b100;
    else case (state_q)
      UNLOCKED:     err_d = op == OP_UNLOCK ? 3'b001 : (op == OP_RDACT || op == OP_RDOVR) ? 3'b101 : 3'b000;
      LOCKED:       err_d = op == OP_UNLOCK ? (key_ok ? 3'b000 : 3'b010) : op == OP_LOCK ? 3'b110 :
                            is_write ? 3'b011 : op == OP_RDOVR ? 3'b101 : 3'b000;
      ROUND_ACTIVE: err_d = (op == OP_UNLOCK || op == OP_LOCK || op == OP_RDACT) ? 3'b101 :
                            is_write ? 3'b011 : 3'b000;
      default:      err_d = 3'b000;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= UNLOCKED;
      ready_q  <= 1'b1;
      err_q    <= 3'b000;
      ro_q     <= 1'b0;
      active_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      mask_q   <= 3'b111;
      charge_q <= DEFAULT_CHARGE;
      tlen_q   <= DEFAULT_TIMER;
      trem_q   <= 16'd0;
      key_q    <= '0;
      cool_q   <= '0;
`ifdef BIDS22_KEY_LOCKOUT_EN
      bad_q    <= 2'd0;
`endif
    end else begin
      err_q <= acc ? err_d : 3'b000;
      ro_q  <= 1'b0;
      case (state_q)
        UNLOCKED: if (ok) begin
          if (op == OP_LOCK) begin
            key_q   <= data;
            state_q <= LOCKED;
          end
          if (op == OP_LOADX) x_q <= data;
          if (op == OP_LOADY) y_q <= data;
          if (op == OP_LOADZ) z_q <= data;
          if (op == OP_MASK) mask_q <= data[2:0];
          if (op == OP_TIMER) tlen_q <= data[15:0] == 16'd0 ? 16'd1 : data[15:0];
          if (op == OP_CHARGE) charge_q <= data;
        end
        LOCKED: begin
          if (ok && op == OP_UNLOCK) begin
            state_q <= UNLOCKED;
`ifdef BIDS22_KEY_LOCKOUT_EN
            bad_q   <= 2'd0;
`endif
          end
          if (ok && op == OP_RDACT) begin
            state_q  <= ROUND_ACTIVE;
            active_q <= 1'b1;
            trem_q   <= tlen_q;
          end
          // bad key: counter preloaded so ready stays low for exactly COOLDOWN_CYCLES cycles
          if (acc && err_d == 3'b010) begin
            ready_q <= 1'b0;
            cool_q  <= CW'(COOLDOWN_CYCLES - 1);
`ifdef BIDS22_KEY_LOCKOUT_EN
            bad_q   <= bad_q + 2'd1;
            state_q <= bad_q == 2'd2 ? LOCKOUT : COOLDOWN;
`else
            state_q <= COOLDOWN;
`endif
          end
        end
        ROUND_ACTIVE: begin
          if (trem_q <= 16'd1 || (ok && op == OP_RDOVR)) begin
            ro_q     <= 1'b1;
            active_q <= 1'b0;
            trem_q   <= 16'd0;
            state_q  <= LOCKED;
          end else trem_q <= trem_q - 16'd1;
        end
        COOLDOWN: begin
          if (cool_q == '0) begin
            ready_q <= 1'b1;
            state_q <= LOCKED;
          end else cool_q <= cool_q - 1'b1;
        end
        default: ;
      endcase
    end
  end
  assign bus.ready       = ready_q;
  assign bus.err         = err_q;
  assign bus.roundOver   = ro_q;
  assign round_active    = active_q;
  assign X_balance       = x_q;
  assign Y_balance       = y_q;
  assign Z_balance       = z_q;
  assign mask            = mask_q;
  assign bid_charge      = charge_q;
  assign timer_remaining = trem_q;
endmodule

// File: doc/bids22_cmd_responder.md
Name: bids22_cmd_responder

Overview:
- Command-side responder of the BIDS22 controller. It receives the opcode/C_data/C_start stream issued by the tester/BFM initiator and executes it.
- Owns the lock/key state, the bidder balance registers, the bid mask, the bid charge and round timer, and round activation.
- Reports per-command status on ready/err and signals round completion on roundOver.
- The bidder-side arbitration logic reads its register outputs.

Parameters:
- CDATA_W, 32, width of C_data and balance/charge registers
- COOLDOWN_CYCLES, 7, cycles ready is held low after a bad unlock key
- DEFAULT_TIMER, 16'h000F, round length after reset
- DEFAULT_CHARGE, 32'h1, bid charge after reset

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high reset
- C_start  in  1  command strobe, sampled only when ready=1
- C_op  in  4  opcode: 0 NoOp, 1 Unlock, 2 Lock, 3 LoadX, 4 LoadY, 5 LoadZ, 6 SetMask, 7 SetTimer, 8 BidCharge, 9 RoundActive, 10 RoundOver, 11-15 illegal
- C_data  in  CDATA_W  command operand
- ready  out  1  responder can accept a command this cycle
- err  out  3  status of the previous accepted command, valid for 1 cycle
- roundOver  out  1  1-cycle pulse when a round ends
- round_active  out  1  round in progress
- X_balance/Y_balance/Z_balance  out  CDATA_W  loaded bidder balances
- mask  out  3  bidder enable mask {Z,Y,X}
- bid_charge  out  CDATA_W  charge per bid
- timer_remaining  out  16  round cycles remaining

Behaviour:
- Reset values:
  - state UNLOCKED
  - ready=1, err=0, roundOver=0, round_active=0
  - balances=0, mask=3'b111, bid_charge=DEFAULT_CHARGE
  - timer length=DEFAULT_TIMER, timer_remaining=0, key=0
- Reset mid-round or mid-cooldown aborts immediately to the reset values.
- Handshake:
  - A command is accepted on a clk edge with C_start=1 and ready=1.
  - err is registered on the next edge and held exactly 1 cycle, then returns to 0.
  - C_start while ready=0 is ignored: no err, no state change.
  - Back-to-back commands on consecutive cycles are legal.
- Error codes:
  - 000 OK
  - 001 Unlock while already unlocked
  - 010 bad key
  - 011 write op (3-8) while not UNLOCKED
  - 100 illegal opcode
  - 101 RoundActive/RoundOver in the wrong state
  - 110 Lock while not UNLOCKED
  - Every errored command leaves all registers unchanged.
- State machine:
  - UNLOCKED:
    - Lock stores key=C_data and goes to LOCKED.
    - LoadX/Y/Z write C_data to the matching balance.
    - SetMask writes C_data[2:0].
    - SetTimer writes C_data[15:0]; the value 0 is stored as 1.
    - BidCharge writes C_data.
    - RoundActive gives err 101.
  - LOCKED:
    - Unlock with C_data==key goes to UNLOCKED.
    - Unlock with a mismatching key gives err 010 and goes to COOLDOWN.
    - RoundActive goes to ROUND_ACTIVE, sets round_active=1 and loads timer_remaining=timer length.
  - ROUND_ACTIVE:
    - timer_remaining decrements by 1 every cycle.
    - When it reaches 0, or on a RoundOver command: roundOver pulses for 1 cycle, round_active=0, state returns to LOCKED. timer_remaining stays at 0.
    - If RoundOver arrives on the same cycle timer_remaining reaches 0: exactly one roundOver pulse, err=000.
    - Unlock, Lock and write ops in this state give err 101 for Unlock/Lock and 011 for write ops.
  - COOLDOWN:
    - ready=0 for COOLDOWN_CYCLES cycles, then state returns to LOCKED with ready=1.
- NoOp in any ready state: err 000, no change.
- No arithmetic wrap: the timer saturates at 0; balances are written only by loads.

Optional Feature:
- Macro BIDS22_KEY_LOCKOUT_EN.
- Defined:
  - A 2-bit counter tracks consecutive bad keys; it clears on a good unlock.
  - The third consecutive bad key enters LOCKOUT.
  - LOCKOUT holds ready=0 until reset; only reset exits it.
- Undefined:
  - No counter.
  - Every bad key takes only COOLDOWN.

Test Plan:
- Reset, then LoadX 32'h0000_1234, SetMask 3'b101, SetTimer 16'h0003 -> err=000 after each; X_balance=32'h1234, mask=3'b101.
- Lock C_data=32'hA5A5_A5A5, then LoadY 32'hFFFF_FFFF -> err=011, Y_balance stays 0.
- Unlock with 32'h0 -> err=010, ready=0 for exactly 7 cycles. Then Unlock 32'hA5A5_A5A5 -> err=000, state UNLOCKED.
- Lock, RoundActive with timer=3 -> round_active=1. timer_remaining counts 3,2,1,0; roundOver pulses once on the cycle it reaches 0; round_active falls to 0.
- C_op=4'hC -> err=100. C_start with ready=0 during cooldown -> no err, no change. Assert reset during ROUND_ACTIVE -> all outputs return to their reset values on the next edge.
- With BIDS22_KEY_LOCKOUT_EN defined: three bad keys in a row -> ready stays 0 for 100 cycles, and returns to 1 only after reset.
